lane_packer: RTL and testbench

Serial-to-parallel frame packer with valid/ready handshakes on both sides. Accepts one 32-bit word per cycle from the word stream and packs up to LANES words into a flattened lane vector. The lane vector feeds the wide-datapath compute stage. Two internal frame banks (ping-pong) sustain one word per cycle while the consumer holds a completed frame. `in_last` closes short frames, which are zero-padded.

---
 rtl/lane_packer_if.sv | 39 +++
 rtl/lane_packer.sv | 135 +++++++++++++
 tb/tb_lane_packer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_packer_if.sv
// Handshake bundle between a word-stream source, the lane packer and the
// wide-datapath consumer. The packer takes the slave view, the environment
// driving words in and taking frames out takes the master view.
interface lane_packer_if #(
    parameter int LANES = 8
) ();

    logic [31:0]             in_word;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [LANES*32-1:0]     out_lanes;
    logic [$clog2(LANES):0]  out_count;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_word,
        input  in_valid,
        input  in_last,
        output in_ready,
        output out_lanes,
        output out_count,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_word,
        output in_valid,
        output in_last,
        input  in_ready,
        input  out_lanes,
        input  out_count,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/lane_packer.sv
// Serial-to-parallel frame packer. Words are written one per cycle into one of
// two frame banks; a completed bank is presented as a flattened lane vector
// while the other bank keeps filling, so the source is only stalled when the
// consumer is holding two complete frames.
module lane_packer #(
    parameter int LANES = 8
) (
    input  logic               clk,
    input  logic               reset,
    lane_packer_if.slave       bus,
    output logic [31:0]        frame_count
);

    localparam int IW = $clog2(LANES);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_status_t;

    logic [31:0]   bank_data     [2][LANES];
    logic [31:0]   bank_data_n   [2][LANES];
    bank_status_t  bank_status   [2];
    bank_status_t  bank_status_n [2];
    logic [CW-1:0] bank_count    [2];
    logic [CW-1:0] bank_count_n  [2];

    logic          wr_sel;
    logic          wr_sel_n;
    logic          rd_sel;
    logic          rd_sel_n;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;
    logic [31:0]   frame_cnt;
    logic [31:0]   frame_cnt_n;

    logic          ready_int;
    logic          valid_int;
    logic          accept;
    logic          consume;
    logic          closing;

    // Handshake qualifiers; in_ready looks only at registered bank status so
    // out_ready never reaches it combinationally.
    always_comb begin
        ready_int = (bank_status[wr_sel] != FULL);
        valid_int = (bank_status[rd_sel] == FULL);
        accept    = bus.in_valid && ready_int;
        consume   = valid_int && bus.out_ready;
        closing   = accept && ((idx == IW'(LANES - 1)) || bus.in_last);
    end

    // Next-state logic: the write bank and the read bank are never the same
    // bank when both an accept and a consume happen, so both updates can be
    // applied independently in the same cycle.
    always_comb begin
        bank_data_n   = bank_data;
        bank_status_n = bank_status;
        bank_count_n  = bank_count;
        wr_sel_n      = wr_sel;
        rd_sel_n      = rd_sel;
        idx_n         = idx;
        frame_cnt_n   = frame_cnt;

        if (accept) begin
            if (idx == '0) begin
                for (int l = 0; l < LANES; l++) begin
                    bank_data_n[wr_sel][l] = (l == 0) ? bus.in_word : 32'd0;
                end
                bank_status_n[wr_sel] = FILLING;
            end else begin
                bank_data_n[wr_sel][idx] = bus.in_word;
            end

            if (closing) begin
                bank_status_n[wr_sel] = FULL;
                bank_count_n[wr_sel]  = CW'(idx) + CW'(1);
                wr_sel_n              = ~wr_sel;
                idx_n                 = '0;
            end else begin
                idx_n = idx + IW'(1);
            end
        end

        if (consume) begin
            bank_status_n[rd_sel] = EMPTY;
            rd_sel_n              = ~rd_sel;
            frame_cnt_n           = frame_cnt + 32'd1;
        end
    end

    // State register; reset discards both banks, including held frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    bank_data[b][l] <= 32'd0;
                end
                bank_status[b] <= EMPTY;
                bank_count[b]  <= '0;
            end
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            idx       <= '0;
            frame_cnt <= 32'd0;
        end else begin
            bank_data   <= bank_data_n;
            bank_status <= bank_status_n;
            bank_count  <= bank_count_n;
            wr_sel      <= wr_sel_n;
            rd_sel      <= rd_sel_n;
            idx         <= idx_n;
            frame_cnt   <= frame_cnt_n;
        end
    end

    // Output presentation: the read bank is shown only while it holds a
    // complete frame, otherwise data and count read as zero.
    always_comb begin
        bus.in_ready  = ready_int;
        bus.out_valid = valid_int;
        bus.out_lanes = '0;
        bus.out_count = '0;
        if (valid_int) begin
            for (int l = 0; l < LANES; l++) begin
                bus.out_lanes[32*l +: 32] = bank_data[rd_sel][l];
            end
            bus.out_count = bank_count[rd_sel];
        end
        frame_count = frame_cnt;
    end

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer with LANES=8: a vector table for the
// basic and short-frame behaviour, hand-written multi-cycle sequences for
// backpressure, throughput, reset and counter wrap, and a randomized run
// checked against a queue-based frame model.
module tb_lane_packer;

    localparam int LANES = 8;
    typedef logic [LANES*32-1:0] vec_t;

    typedef struct {
        logic [31:0] word;
        logic        valid;
        logic        last;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        int          exp_cnt;
        logic [31:0] exp_l0;
        logic [31:0] exp_l2;
        logic [31:0] exp_l7;
        logic [31:0] exp_fc;
    } row_t;

    logic        clk;
    logic        reset;
    logic [31:0] frame_count;

    lane_packer_if #(.LANES(LANES)) bus ();

    lane_packer #(.LANES(LANES)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .frame_count (frame_count)
    );

    int n_checks;
    int n_fail;

    // Reference model: completed frames waiting for the consumer and the
    // words collected so far for the frame being built.
    vec_t        exp_q[$];
    int          exp_cnt_q[$];
    logic [31:0] partial[$];
    logic [31:0] model_fc;

    row_t rows[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] lane_of(vec_t v, int i);
        return v[32*i +: 32];
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_vec(string name, vec_t act, vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_row(logic [31:0] word, logic valid, logic last, logic ordy,
                           logic exp_ir, logic exp_ov, int exp_cnt,
                           logic [31:0] exp_l0, logic [31:0] exp_l2,
                           logic [31:0] exp_l7, logic [31:0] exp_fc);
        row_t r;
        r.word = word; r.valid = valid; r.last = last; r.ordy = ordy;
        r.exp_ir = exp_ir; r.exp_ov = exp_ov; r.exp_cnt = exp_cnt;
        r.exp_l0 = exp_l0; r.exp_l2 = exp_l2; r.exp_l7 = exp_l7; r.exp_fc = exp_fc;
        rows.push_back(r);
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_cnt_q.delete();
        partial.delete();
        model_fc = 32'd0;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_word   = 32'd0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic send_word(logic [31:0] w, logic last);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_model();
        vec_t exp_lanes;
        int   exp_cnt;
        exp_lanes = '0;
        exp_cnt   = 0;
        if (exp_q.size() > 0) begin
            exp_lanes = exp_q[0];
            exp_cnt   = exp_cnt_q[0];
        end
        check32("rand in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
        check32("rand out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        check32("rand out_count", 32'(bus.out_count), 32'(exp_cnt));
        check_vec("rand out_lanes", bus.out_lanes, exp_lanes);
        check32("rand frame_count", frame_count, model_fc);
    endtask

    initial begin
        int          accepted;
        int          stalls;
        int          frames_seen;
        logic [31:0] w;
        logic        acc;
        logic        con;
        logic        hold;
        vec_t        v;

        n_checks = 0;
        n_fail   = 0;
        model_clear();

        // ---------------- reset state ----------------
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_word   = 32'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check32("reset in_ready", 32'(bus.in_ready), 32'd1);
        check32("reset out_valid", 32'(bus.out_valid), 32'd0);
        check32("reset out_count", 32'(bus.out_count), 32'd0);
        check_vec("reset out_lanes", bus.out_lanes, '0);
        check32("reset frame_count", frame_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- vector table: basic + short frames ----------------
        for (int i = 0; i < 7; i++) begin
            add_row(32'h10 + 32'(i), 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        end
        add_row(32'h17, 1, 0, 1, 1, 1, 8, 32'h10, 32'h12, 32'h17, 0);
        add_row(32'h0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        add_row(32'h20, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        add_row(32'h21, 1, 1, 1, 1, 1, 2, 32'h20, 0, 0, 1);
        add_row(32'h0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 2);
        add_row(32'hA,  1, 0, 1, 1, 0, 0, 0, 0, 0, 2);
        add_row(32'hB,  1, 0, 1, 1, 0, 0, 0, 0, 0, 2);
        add_row(32'hC,  1, 1, 1, 1, 1, 3, 32'hA, 32'hC, 0, 2);
        add_row(32'h0,  0, 0, 0, 1, 1, 3, 32'hA, 32'hC, 0, 2);
        add_row(32'h0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 3);

        foreach (rows[i]) begin
            bus.in_word   = rows[i].word;
            bus.in_valid  = rows[i].valid;
            bus.in_last   = rows[i].last;
            bus.out_ready = rows[i].ordy;
            @(negedge clk);
            check32($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(rows[i].exp_ir));
            check32($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(rows[i].exp_ov));
            check32($sformatf("row%0d out_count", i), 32'(bus.out_count), 32'(rows[i].exp_cnt));
            check32($sformatf("row%0d lane0", i), lane_of(bus.out_lanes, 0), rows[i].exp_l0);
            check32($sformatf("row%0d lane2", i), lane_of(bus.out_lanes, 2), rows[i].exp_l2);
            check32($sformatf("row%0d lane7", i), lane_of(bus.out_lanes, 7), rows[i].exp_l7);
            check32($sformatf("row%0d frame_count", i), frame_count, rows[i].exp_fc);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // ---------------- backpressure ----------------
        do_reset();
        bus.out_ready = 1'b0;
        w        = 32'h100;
        accepted = 0;
        for (int c = 0; c < 24; c++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = w;
            bus.in_last  = 1'b0;
            acc = bus.in_ready;
            @(negedge clk);
            if (acc) begin
                accepted++;
                w++;
            end
        end
        bus.in_valid = 1'b0;
        check32("bp accepted", 32'(accepted), 32'd16);
        check32("bp in_ready low", 32'(bus.in_ready), 32'd0);
        check32("bp first frame lane0", lane_of(bus.out_lanes, 0), 32'h100);
        check32("bp first frame lane7", lane_of(bus.out_lanes, 7), 32'h107);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check32("bp in_ready after consume", 32'(bus.in_ready), 32'd1);
        check32("bp second frame lane0", lane_of(bus.out_lanes, 0), 32'h108);
        check32("bp second frame lane7", lane_of(bus.out_lanes, 7), 32'h10F);
        check32("bp frame_count 1", frame_count, 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check32("bp drained out_valid", 32'(bus.out_valid), 32'd0);
        check32("bp frame_count 2", frame_count, 32'd2);

        // ---------------- full throughput ----------------
        do_reset();
        stalls      = 0;
        frames_seen = 0;
        for (int c = 0; c < 802; c++) begin
            if (c < 800 && bus.in_ready !== 1'b1) stalls++;
            if (bus.out_valid === 1'b1) begin
                v = '0;
                for (int l = 0; l < LANES; l++) begin
                    v[32*l +: 32] = 32'h1000_0000 + 32'(frames_seen * LANES + l);
                end
                check_vec($sformatf("tp frame%0d", frames_seen), bus.out_lanes, v);
                frames_seen++;
            end
            bus.out_ready = 1'b1;
            bus.in_valid  = (c < 800);
            bus.in_word   = 32'h1000_0000 + 32'(c);
            bus.in_last   = (c < 800) && ((c % 16) == 15);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check32("tp in_ready stalls", 32'(stalls), 32'd0);
        check32("tp frames seen", 32'(frames_seen), 32'd100);
        check32("tp frame_count", frame_count, 32'd100);

        // ---------------- reset mid-operation ----------------
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(32'h200 + 32'(i), 1'b0);
        @(negedge clk);
        check32("rst pre frame_count", frame_count, 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(32'h210 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) send_word(32'h220 + 32'(i), 1'b0);
        check32("rst pre out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check32("rst async out_valid", 32'(bus.out_valid), 32'd0);
        check32("rst async out_count", 32'(bus.out_count), 32'd0);
        check_vec("rst async out_lanes", bus.out_lanes, '0);
        check32("rst async frame_count", frame_count, 32'd0);
        check32("rst async in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(32'h300 + 32'(i), 1'b0);
        check32("rst post out_valid", 32'(bus.out_valid), 32'd1);
        check32("rst post out_count", 32'(bus.out_count), 32'd8);
        check32("rst post lane0", lane_of(bus.out_lanes, 0), 32'h300);
        check32("rst post lane7", lane_of(bus.out_lanes, 7), 32'h307);
        @(negedge clk);
        check32("rst post frame_count", frame_count, 32'd1);

        // ---------------- frame_count wrap ----------------
        do_reset();
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        #1;
        check32("wrap preset", frame_count, 32'hFFFF_FFFF);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(32'h400 + 32'(i), 1'b0);
        @(negedge clk);
        check32("wrap frame_count", frame_count, 32'd0);

        // ---------------- randomized run against the model ----------------
        do_reset();
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_word  = $urandom;
                bus.in_last  = ($urandom_range(0, 5) == 0);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            check_model();
            acc = bus.in_valid && (exp_q.size() < 2);
            con = bus.out_ready && (exp_q.size() > 0);
            @(negedge clk);
            if (con) begin
                void'(exp_q.pop_front());
                void'(exp_cnt_q.pop_front());
                model_fc = model_fc + 32'd1;
            end
            if (acc) begin
                partial.push_back(bus.in_word);
                if (partial.size() == LANES || bus.in_last) begin
                    v = '0;
                    foreach (partial[i]) v[32*i +: 32] = partial[i];
                    exp_q.push_back(v);
                    exp_cnt_q.push_back(partial.size());
                    partial.delete();
                end
            end
            hold = bus.in_valid && !acc;
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
